// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: requester indices, requester count, FSM encoding and a one-hot decode helper
package mem_port_arbiter_pkg;

    localparam int REQ_IFETCH = 0;
    localparam int REQ_DREAD  = 1;
    localparam int REQ_WBUF   = 2;
    localparam int NUM_REQ    = 3;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        RESP = 2'b10
    } state_t;

    function automatic logic [1:0] onehot_idx(input logic [NUM_REQ-1:0] oh);
        return oh[REQ_WBUF] ? 2'(REQ_WBUF) : oh[REQ_DREAD] ? 2'(REQ_DREAD) : 2'(REQ_IFETCH);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester-side and memory-side bus of the shared memory port
interface mem_port_arbiter_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int BLOCK_WIDTH   = 32
);
    logic [2:0]               req;
    logic [2:0]               req_wr;
    logic [3*ADDRESS_WIDTH-1:0] req_address;
    logic [3*BLOCK_WIDTH-1:0] req_wdata;
    logic [2:0]               gnt;
    logic [2:0]               done;
    logic [BLOCK_WIDTH-1:0]   rdata;
    logic                     mem_enable;
    logic                     mem_wr;
    logic [ADDRESS_WIDTH-1:0] mem_address;
    logic [BLOCK_WIDTH-1:0]   mem_wdata;
    logic                     mem_done;
    logic [BLOCK_WIDTH-1:0]   mem_data_out;

    modport slave (
        input  req, req_wr, req_address, req_wdata, mem_done, mem_data_out,
        output gnt, done, rdata, mem_enable, mem_wr, mem_address, mem_wdata
    );

    modport master (
        output req, req_wr, req_address, req_wdata, mem_done, mem_data_out,
        input  gnt, done, rdata, mem_enable, mem_wr, mem_address, mem_wdata
    );
endinterface

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner select; round-robin from ptr with MEM_ARB_RR_EN, else fixed 1 > 0 > 2
module mem_arb_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         ptr,
    output logic [NUM_REQ-1:0] win
);
`ifdef MEM_ARB_RR_EN
    // scan downwards so the requester closest to ptr is the last one written and wins
    always_comb begin
        win = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (req[(int'(ptr) + k) % NUM_REQ]) win = 3'(1) << ((int'(ptr) + k) % NUM_REQ);
    end
`else
    logic unused_ptr;
    assign unused_ptr = ^ptr;
    // D-read first, then I-fetch, then write-buffer drain
    always_comb begin
        win = req[REQ_DREAD]  ? 3'(1) << REQ_DREAD  :
              req[REQ_IFETCH] ? 3'(1) << REQ_IFETCH :
              req[REQ_WBUF]   ? 3'(1) << REQ_WBUF   : '0;
    end
`endif
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: three-requester single-port memory arbiter (IDLE/BUSY/RESP); MEM_ARB_RR_EN selects round-robin
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int BLOCK_WIDTH   = 32
) (
    input logic clk,
    input logic rst,
    mem_port_arbiter_if.slave bus
);
    state_t                   state_q, state_d;
    logic [NUM_REQ-1:0]       gnt_q, gnt_d, done_q, done_d, win;
    logic [BLOCK_WIDTH-1:0]   rdata_q, rdata_d, mem_wdata_q, mem_wdata_d;
    logic [ADDRESS_WIDTH-1:0] mem_address_q, mem_address_d;
    logic                     mem_enable_q, mem_enable_d, mem_wr_q, mem_wr_d;
    logic [1:0]               win_idx, ptr;

`ifdef MEM_ARB_RR_EN
    logic [1:0] ptr_q, ptr_d;
    assign ptr = ptr_q;
`else
    assign ptr = 2'd0;
`endif

    mem_arb_pick u_pick (.req(bus.req), .ptr(ptr), .win(win));

    assign win_idx = onehot_idx(win);

    // next-state and next-output computation for the single transaction FSM
    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        done_d        = '0;
        rdata_d       = rdata_q;
        mem_enable_d  = mem_enable_q;
        mem_wr_d      = mem_wr_q;
        mem_address_d = mem_address_q;
        mem_wdata_d   = mem_wdata_q;
`ifdef MEM_ARB_RR_EN
        ptr_d         = ptr_q;
`endif
        case (state_q)
            IDLE: if (|bus.req) begin
                state_d       = BUSY;
                gnt_d         = win;
                mem_enable_d  = 1'b1;
                mem_wr_d      = bus.req_wr[win_idx];
                mem_address_d = bus.req_address[int'(win_idx)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                mem_wdata_d   = bus.req_wdata[int'(win_idx)*BLOCK_WIDTH +: BLOCK_WIDTH];
`ifdef MEM_ARB_RR_EN
                ptr_d         = 2'((int'(win_idx) + 1) % NUM_REQ);
`endif
            end
            BUSY: if (bus.mem_done) begin
                state_d      = RESP;
                mem_enable_d = 1'b0;
                mem_wr_d     = 1'b0;
                done_d       = gnt_q;
                rdata_d      = mem_wr_q ? rdata_q : bus.mem_data_out;
            end
            RESP: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // register state and every output; active-low synchronous reset abandons any transaction
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            gnt_q         <= '0;
            done_q        <= '0;
            rdata_q       <= '0;
            mem_enable_q  <= 1'b0;
            mem_wr_q      <= 1'b0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
`ifdef MEM_ARB_RR_EN
            ptr_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            done_q        <= done_d;
            rdata_q       <= rdata_d;
            mem_enable_q  <= mem_enable_d;
            mem_wr_q      <= mem_wr_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
`ifdef MEM_ARB_RR_EN
            ptr_q         <= ptr_d;
`endif
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.done        = done_q;
    assign bus.rdata       = rdata_q;
    assign bus.mem_enable  = mem_enable_q;
    assign bus.mem_wr      = mem_wr_q;
    assign bus.mem_address = mem_address_q;
    assign bus.mem_wdata   = mem_wdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter; honours MEM_ARB_RR_EN for grant order
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int BW = 32;

    typedef struct {
        logic [2:0]    done;
        logic [BW-1:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int total = 0;
    int bad = 0;
    exp_t exp_q[$];
    logic [BW-1:0] last_rd = '0;

    mem_port_arbiter_if #(.ADDRESS_WIDTH(AW), .BLOCK_WIDTH(BW)) bus ();

    mem_port_arbiter #(.ADDRESS_WIDTH(AW), .BLOCK_WIDTH(BW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // scoreboard: every done pulse must match the oldest expected completion
    always @(negedge clk) begin
        if (bus.done != 3'b000) begin
            if (exp_q.size() == 0) chk("spurious_done", 64'(bus.done), 64'd0);
            else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("done", 64'(bus.done), 64'(e.done));
                chk("rdata", 64'(bus.rdata), 64'(e.rdata));
            end
        end
    end

    // called while the DUT is in IDLE with requests already driven
    task automatic txn(input string tag, input logic [2:0] eg, input logic [AW-1:0] ea, input logic ew,
                       input logic [BW-1:0] ed, input int lat, input logic [BW-1:0] md, input logic [2:0] drop);
        logic [3*AW-1:0] sa;
        logic [3*BW-1:0] sd;
        logic [2:0] sw;
        exp_q.push_back('{done: eg, rdata: ew ? last_rd : md});
        if (!ew) last_rd = md;
        sa = bus.req_address;
        sd = bus.req_wdata;
        sw = bus.req_wr;
        bus.mem_data_out = ~md;
        @(posedge clk); #1;
        chk({tag, "_gnt"}, 64'(bus.gnt), 64'(eg));
        for (int i = 0; i < lat; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            if (i == 1) begin
                bus.req = bus.req & ~drop;
                bus.req_address = ~sa;
                bus.req_wdata = ~sd;
                bus.req_wr = ~sw;
            end
            chk({tag, "_en"}, 64'(bus.mem_enable), 64'd1);
            chk({tag, "_addr"}, 64'(bus.mem_address), 64'(ea));
            chk({tag, "_wr"}, 64'(bus.mem_wr), 64'(ew));
            if (ew) chk({tag, "_wdata"}, 64'(bus.mem_wdata), 64'(ed));
            if (i == lat - 1) begin
                bus.mem_done = 1'b1;
                bus.mem_data_out = md;
            end
        end
        @(posedge clk); #1;
        bus.mem_done = 1'b0;
        bus.mem_data_out = ~md;
        bus.req_address = sa;
        bus.req_wdata = sd;
        bus.req_wr = sw;
        chk({tag, "_en_off"}, 64'(bus.mem_enable), 64'd0);
        chk({tag, "_wr_off"}, 64'(bus.mem_wr), 64'd0);
    endtask

    task automatic to_idle(input string tag);
        @(posedge clk); #1;
        chk({tag, "_gnt_clr"}, 64'(bus.gnt), 64'd0);
        @(posedge clk); #1;
        chk({tag, "_idle_en"}, 64'(bus.mem_enable), 64'd0);
    endtask

    initial begin
        logic [2:0] seq[$];
        int idx;
        rst = 1'b0;
        bus.req = '0;
        bus.req_wr = '0;
        bus.req_address = '0;
        bus.req_wdata = '0;
        bus.mem_done = 1'b0;
        bus.mem_data_out = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", 64'(bus.gnt), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_en", 64'(bus.mem_enable), 64'd0);
        chk("rst_wr", 64'(bus.mem_wr), 64'd0);
        chk("rst_addr", 64'(bus.mem_address), 64'd0);
        chk("rst_wdata", 64'(bus.mem_wdata), 64'd0);
        chk("rst_rdata", 64'(bus.rdata), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        bus.req_address[1*AW +: AW] = 32'h100;
        bus.req = 3'b010;
        txn("rd", 3'b010, 32'h100, 1'b0, '0, 3, 32'hDEADBEEF, 3'b000);
        bus.req = 3'b000;
        to_idle("rd");

        bus.req_address[2*AW +: AW] = 32'h40;
        bus.req_wdata[2*BW +: BW] = 32'h12345678;
        bus.req_wr = 3'b100;
        bus.req = 3'b100;
        txn("wr", 3'b100, 32'h40, 1'b1, 32'h12345678, 2, 32'hBAD0BAD0, 3'b000);
        bus.req = 3'b000;
        bus.req_wr = 3'b000;
        to_idle("wr");
        chk("wr_rdata_kept", 64'(bus.rdata), 64'hDEADBEEF);

        bus.req_address[0*AW +: AW] = 32'h200;
        bus.req = 3'b001;
        txn("drop", 3'b001, 32'h200, 1'b0, '0, 3, 32'h0BADCAFE, 3'b001);
        chk("drop_req_low", 64'(bus.req), 64'd0);
        to_idle("drop");

        bus.mem_done = 1'b1;
        bus.mem_data_out = 32'hFFFFFFFF;
        @(posedge clk); #1;
        bus.mem_done = 1'b0;
        chk("idle_md_gnt", 64'(bus.gnt), 64'd0);
        chk("idle_md_en", 64'(bus.mem_enable), 64'd0);
        chk("idle_md_done", 64'(bus.done), 64'd0);
        @(posedge clk); #1;
        chk("idle_md_rdata", 64'(bus.rdata), 64'(last_rd));

`ifdef MEM_ARB_RR_EN
        seq = '{3'b010, 3'b100, 3'b001, 3'b010};
`else
        seq = '{3'b010, 3'b010, 3'b010};
`endif
        for (int i = 0; i < 3; i++) bus.req_address[i*AW +: AW] = 32'h1000 + 32'(i) * 32'h10;
        bus.req_wr = 3'b000;
        bus.req = 3'b111;
        for (int k = 0; k < seq.size(); k++) begin
            idx = seq[k][0] ? 0 : seq[k][1] ? 1 : 2;
            txn("arb", seq[k], 32'h1000 + 32'(idx) * 32'h10, 1'b0, '0, 1 + k % 2, 32'hA0000000 + 32'(k), 3'b000);
            if (k == seq.size() - 1) bus.req = 3'b000;
            @(posedge clk); #1;
            chk("arb_gap_gnt", 64'(bus.gnt), 64'd0);
            chk("arb_gap_en", 64'(bus.mem_enable), 64'd0);
        end

        bus.req_address[1*AW +: AW] = 32'h300;
        bus.req = 3'b010;
        @(posedge clk); #1;
        chk("rb_gnt", 64'(bus.gnt), 64'b010);
        chk("rb_en", 64'(bus.mem_enable), 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.req = 3'b000;
        @(posedge clk); #1;
        chk("rb_en_off", 64'(bus.mem_enable), 64'd0);
        chk("rb_gnt_off", 64'(bus.gnt), 64'd0);
        chk("rb_addr", 64'(bus.mem_address), 64'd0);
        chk("rb_rdata", 64'(bus.rdata), 64'd0);
        rst = 1'b1;
        last_rd = '0;
        bus.mem_done = 1'b1;
        bus.mem_data_out = 32'h55555555;
        @(posedge clk); #1;
        bus.mem_done = 1'b0;
        chk("rb_md_en", 64'(bus.mem_enable), 64'd0);
        chk("rb_md_done", 64'(bus.done), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rb_final_gnt", 64'(bus.gnt), 64'd0);
        chk("rb_final_rdata", 64'(bus.rdata), 64'd0);

        chk("pending", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
